// File: rtl/approx_mul_err_sweep.sv
// Exhaustive error sweep for an NxN approximate multiplier.
// Walks every operand pair and accumulates error statistics.
module approx_mul_err_sweep #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [N-1:0]     op_a,
    output logic [N-1:0]     op_b,
    input  logic [2*N-1:0]   prod_in,
    output logic             busy,
    output logic             done,
    output logic [2*N:0]     err_cnt,
    output logic [2*N-1:0]   max_ed,
    output logic [4*N:0]     sum_ed,
    output logic [4*N+1:0]   sum_err
);

    localparam int W = 2 * N;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t       state;
    state_t       nxt;
    logic [W-1:0] idx;
    logic         dcnt;
    logic         go;
    logic         last;

    logic         v1;
    logic [W-1:0] p1;
    logic [W-1:0] e1;
    logic [W-1:0] exact;

    logic [W:0]   diff;
    logic [W-1:0] ed;

    assign go    = start && (state == IDLE || state == DONE);
    assign last  = &idx;
    assign op_a  = idx[W-1:N];
    assign op_b  = idx[N-1:0];
    assign busy  = (state == RUN) || (state == DRAIN);
    assign done  = (state == DONE);
    assign exact = W'(op_a) * W'(op_b);

    assign diff  = {1'b0, p1} - {1'b0, e1};
    assign ed    = (p1 >= e1) ? (p1 - e1) : (e1 - p1);

    // Next-state: sweep until the all-ones index, then flush two cycles.
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (start) nxt = RUN;
            RUN:     if (last)  nxt = DRAIN;
            DRAIN:   if (dcnt)  nxt = DONE;
            DONE:    if (start) nxt = RUN;
            default: nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // Operand index walks {a,b}; holds at all-ones after the last pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx  <= '0;
            dcnt <= 1'b0;
        end else begin
            if (go)
                idx <= '0;
            else if (state == RUN && !last)
                idx <= idx + W'(1);
            dcnt <= (state == DRAIN) ? ~dcnt : 1'b0;
        end
    end

    // S1: capture the approximate and exact products of the presented pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            p1 <= '0;
            e1 <= '0;
        end else begin
            v1 <= (state == RUN);
            p1 <= prod_in;
            e1 <= exact;
        end
    end

    // S2: fold the captured error into the running statistics.
    always_ff @(posedge clk) begin
        if (rst || go) begin
            err_cnt <= '0;
            max_ed  <= '0;
            sum_ed  <= '0;
            sum_err <= '0;
        end else if (v1) begin
            err_cnt <= err_cnt + (W+1)'(ed != '0);
            if (ed > max_ed)
                max_ed <= ed;
            sum_ed  <= sum_ed + (4*N+1)'(ed);
            sum_err <= sum_err + {{(W+1){diff[W]}}, diff};
        end
    end

endmodule

// File: tb/tb_approx_mul_err_sweep.sv
// Bench for approx_mul_err_sweep: full N=4 sweeps with stub multipliers,
// plus an N=8 instance for sweep-order and early accumulation checks.
module tb_approx_mul_err_sweep;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic [7:0]  p4;
    logic        busy4;
    logic        done4;
    logic [8:0]  ec4;
    logic [7:0]  mx4;
    logic [16:0] se4;
    logic [17:0] sr4;
    int          mode;

    logic        rst8;
    logic        start8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [15:0] p8;
    logic        busy8;
    logic        done8;
    logic [16:0] ec8;
    logic [15:0] mx8;
    logic [32:0] se8;
    logic [33:0] sr8;

    // Stub multipliers: 0 exact, 1 zero, 2 exact plus one.
    always_comb begin
        p4 = 8'd0;
        case (mode)
            0:       p4 = {4'b0, a4} * {4'b0, b4};
            1:       p4 = 8'd0;
            default: p4 = {4'b0, a4} * {4'b0, b4} + 8'd1;
        endcase
    end

    assign p8 = {8'b0, a8} * {8'b0, b8} + 16'd1;

    approx_mul_err_sweep #(.N(4)) u4 (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op_a    (a4),
        .op_b    (b4),
        .prod_in (p4),
        .busy    (busy4),
        .done    (done4),
        .err_cnt (ec4),
        .max_ed  (mx4),
        .sum_ed  (se4),
        .sum_err (sr4)
    );

    approx_mul_err_sweep #(.N(8)) u8 (
        .clk     (clk),
        .rst     (rst8),
        .start   (start8),
        .op_a    (a8),
        .op_b    (b8),
        .prod_in (p8),
        .busy    (busy8),
        .done    (done8),
        .err_cnt (ec8),
        .max_ed  (mx8),
        .sum_ed  (se8),
        .sum_err (sr8)
    );

    typedef struct {
        int          mode;
        logic [8:0]  ec;
        logic [7:0]  mx;
        logic [16:0] se;
        logic [17:0] sr;
    } vec_t;

    vec_t tbl [3];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic go4();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_done4(input string nm);
        while (!done4 && cyc < 400) step();
        chk({nm, " done"}, 64'(done4), 64'd1);
        chk({nm, " latency"}, 64'(cyc), 64'd259);
        chk({nm, " busy_end"}, 64'(busy4), 64'd0);
    endtask

    task automatic chk_res(input string nm, input vec_t v);
        chk({nm, " err_cnt"}, 64'(ec4), 64'(v.ec));
        chk({nm, " max_ed"},  64'(mx4), 64'(v.mx));
        chk({nm, " sum_ed"},  64'(se4), 64'(v.se));
        chk({nm, " sum_err"}, 64'(sr4), 64'(v.sr));
    endtask

    initial begin
        tbl[0] = '{1, 9'd225, 8'd225, 17'd14400, 18'(-14400)};
        tbl[1] = '{0, 9'd0,   8'd0,   17'd0,     18'd0};
        tbl[2] = '{2, 9'd256, 8'd1,   17'd256,   18'd256};

        rst    = 1'b1;
        start  = 1'b0;
        mode   = 0;
        rst8   = 1'b1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset state", {a4, b4, busy4, done4, ec4, mx4, se4, sr4},
            64'd0);

        for (int i = 0; i < 3; i++) begin
            mode = tbl[i].mode;
            go4();
            chk("c1 pair", 64'({a4, b4}), 64'h00);
            chk("c1 busy", 64'({busy4, done4}), 64'b10);
            step_to(2);
            chk("c2 pair", 64'({a4, b4}), 64'h01);
            step_to(17);
            chk("c17 pair", 64'({a4, b4}), 64'h10);
            step_to(256);
            chk("c256 pair", 64'({a4, b4}), 64'hff);
            step_to(258);
            chk("drain busy", 64'({busy4, done4, a4, b4}), 64'h2ff);
            wait_done4("sweep");
            chk_res("sweep", tbl[i]);
            repeat (3) step();
            chk("done hold", 64'(done4), 64'd1);
            chk_res("hold", tbl[i]);
        end

        mode = 2;
        go4();
        step_to(100);
        chk("mid idx99", 64'({a4, b4}), 64'd99);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("mid idx100", 64'({a4, b4}), 64'd100);
        chk("mid busy", 64'(busy4), 64'd1);
        wait_done4("midstart");
        chk_res("midstart", tbl[2]);

        go4();
        step_to(150);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst mid", {a4, b4, busy4, done4, ec4, mx4, se4, sr4}, 64'd0);
        repeat (3) step();
        chk("rst idle", 64'({a4, b4, busy4, done4}), 64'd0);
        mode = 1;
        go4();
        wait_done4("after rst");
        chk_res("after rst", tbl[0]);

        rst8 = 1'b0;
        step();
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        cyc = 1;
        chk("n8 c1", 64'({a8, b8, busy8}), 64'h0_0001);
        step_to(2);
        chk("n8 c2", 64'({a8, b8}), 64'h0001);
        step_to(257);
        chk("n8 c257", 64'({a8, b8}), 64'h0100);
        step_to(300);
        chk("n8 err_cnt", 64'(ec8), 64'd298);
        chk("n8 sum_ed", 64'(se8), 64'd298);
        chk("n8 sum_err", 64'(sr8), 64'd298);
        chk("n8 max_ed", 64'({mx8, done8}), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/approx_mul_err_sweep.md
# approx_mul_err_sweep

Exhaustive error-characterisation engine for the 8x8 approximate multipliers. It drives every operand pair into the multiplier under test and consumes the multiplier's 2N-bit product. It compares each product against an internally computed exact product and accumulates error count, maximum error distance, summed error distance and signed error sum. It sits in the evaluation harness directly around the multiplier: upstream on `a`/`b`, downstream on `prod8`.

## Interface
- `N`, default 8: operand width. The multiplier under test is N x N with a 2N-bit product.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  starts a sweep. Sampled only in IDLE or DONE.
- `op_a`  output  N  operand A to the multiplier under test; registered.
- `op_b`  output  N  operand B to the multiplier under test; registered.
- `prod_in`  input  2N  approximate product. It is combinational from `op_a`/`op_b` and valid in the same cycle.
- `busy`  output  1  high from the first operand pair through the final accumulator update.
- `done`  output  1  level signal. High once results are final; stays high until the next accepted `start` or `rst`.
- `err_cnt`  output  2N+1  number of pairs with `prod_in` != exact.
- `max_ed`  output  2N  maximum |prod_in − exact|.
- `sum_ed`  output  4N+1  Σ|prod_in − exact|, unsigned.
- `sum_err`  output  4N+2  Σ(prod_in − exact), two's complement.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DRAIN after the pair (2^N−1, 2^N−1) has been presented.
  - DRAIN → DONE after 2 cycles.
  - DONE → RUN on `start`.
- An accepted `start` clears all four accumulators, sets `{op_a,op_b}` to 0 and clears `done`.
- Sweep order: the 2N-bit index `{op_a,op_b}` increments by 1 per cycle, so `op_b` is the fastest-changing operand. There are 2^(2N) pairs and no gaps or repeats.
- Stage S1, at the end of each RUN cycle: register `prod_in` and exact = `op_a*op_b` (2N bits), plus a valid bit.
- Stage S2, the cycle after S1: compute diff = prod_in − exact at 2N+1 bits signed, and ed = |diff|. When valid:
  - `err_cnt` += (ed != 0)
  - `max_ed` = max(`max_ed`, ed)
  - `sum_ed` += ed
  - `sum_err` += sign-extended diff
- The accumulator widths are sized so that no accumulator can overflow for any possible `prod_in`. No saturation logic.
- `start` while in RUN or DRAIN is ignored.
- `op_a`/`op_b` hold their last value, (2^N−1, 2^N−1), in DRAIN and DONE. In IDLE they are 0.
- `rst` (including mid-sweep) forces IDLE. Reset values:
  - `op_a` = `op_b` = 0
  - `busy` = 0, `done` = 0
  - all accumulators 0
  - pipeline valid bits 0

## Timing
- Cycle 0: `start` is sampled high in IDLE.
- Cycle 1: `busy` = 1 and pair (0,0) is presented.
- Cycle k (1 ≤ k ≤ 2^(2N)) presents index k−1. For N=8, cycle 257 presents (1,0) and cycle 65536 presents (255,255).
- Pair k is captured in S1 at the end of cycle k and accumulated at the end of cycle k+1.
- DRAIN occupies cycles 2^(2N)+1 and 2^(2N)+2. The final accumulation happens at the end of cycle 2^(2N)+1.
- Cycle 2^(2N)+3: `busy` = 0 and `done` = 1, with results stable. Total latency from `start` to `done` is 2^(2N)+3 cycles; 65539 for N=8.
- A restart from DONE behaves identically to a start from IDLE. `done` drops in the cycle after `start` is sampled.
- Accumulator outputs change during a sweep. They are meaningful only while `done` = 1.

## Test plan
- Exact stub, `prod_in` = `op_a*op_b`, N=8 → at cycle 65539: `done` = 1, `err_cnt` = 0, `max_ed` = 0, `sum_ed` = 0, `sum_err` = 0.
- Zero stub, `prod_in` = 0 → `err_cnt` = 65025, `max_ed` = 65025, `sum_ed` = 1065369600, `sum_err` = −1065369600.
- Offset stub, `prod_in` = `op_a*op_b`+1 → `err_cnt` = 65536, `max_ed` = 1, `sum_ed` = 65536, `sum_err` = +65536. Also check the sweep order: (0,0) at cycle 1, (0,1) at cycle 2, (1,0) at cycle 257, (255,255) at cycle 65536.
- `start` pulsed at cycle 100 mid-sweep → ignored: `op_a`/`op_b` continue at index 99 → 100, and `done` still arrives at cycle 65539.
- `rst` at cycle 30000 → next cycle: IDLE, `op_a` = `op_b` = 0, `busy` = 0, `done` = 0, all accumulators 0. A new `start` then gives a full correct sweep.
- Back-to-back runs: zero stub, then `start` in DONE with the exact stub → second results are all 0, proving the accumulators were cleared.
